// File: rtl/regfile_rat_ckpt_pkg.sv
// rtl/regfile_rat_ckpt_pkg.sv - shared sizes, types and the commit-clear helper
// Every tag table in the design is a packed NREG x ROB_BIT vector so it can be copied whole.
package regfile_rat_ckpt_pkg;
  localparam int REG_BIT  = 5;
  localparam int ROB_BIT  = 4;
  localparam int XLEN     = 32;
  localparam int ISSUE_W  = 2;
  localparam int COMMIT_W = 2;
  localparam int CKPT_N   = 4;
  localparam int CKPT_BIT = $clog2(CKPT_N);
  localparam int NREG     = 1 << REG_BIT;

  typedef logic [REG_BIT-1:0]             reg_idx_t;
  typedef logic [ROB_BIT-1:0]             rob_idx_t;
  typedef logic [XLEN-1:0]                word_t;
  typedef logic [CKPT_BIT-1:0]            ckpt_idx_t;
  typedef logic [CKPT_BIT:0]              ckpt_cnt_t;
  typedef logic [NREG-1:0][ROB_BIT-1:0]   tag_tbl_t;

  localparam rob_idx_t ZERO_ROB_IDX = '0;
  localparam word_t    ZERO_WORD    = '0;

  // A committing tag only retires an entry that still names it; compares use the pre-clear table.
  function automatic tag_tbl_t commit_clear(
    input tag_tbl_t                        tbl,
    input logic [COMMIT_W-1:0]             ena,
    input logic [COMMIT_W*REG_BIT-1:0]     rd,
    input logic [COMMIT_W*ROB_BIT-1:0]     idx
  );
    tag_tbl_t res;
    reg_idx_t r;
    res = tbl;
    for (int c = 0; c < COMMIT_W; c++) begin
      r = rd[c*REG_BIT +: REG_BIT];
      if (ena[c] && (r != '0) && (tbl[r] == idx[c*ROB_BIT +: ROB_BIT])) begin
        res[r] = ZERO_ROB_IDX;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/regfile_rat_ckpt_if.sv
// rtl/regfile_rat_ckpt_if.sv - rename/commit/checkpoint bus between IDU, ROB and the regfile
interface regfile_rat_ckpt_if;
  import regfile_rat_ckpt_pkg::*;

  logic                          rdy;
  logic                          reg_st;
  logic                          reg_rb;
  logic [ISSUE_W*2*REG_BIT-1:0]  id_rs;
  logic [ISSUE_W*2*ROB_BIT-1:0]  id_src;
  logic [ISSUE_W*2*XLEN-1:0]     id_val;
  logic [ISSUE_W-1:0]            id_rn_ena;
  logic [ISSUE_W*REG_BIT-1:0]    id_rn_rd;
  logic [ISSUE_W*ROB_BIT-1:0]    id_rn_idx;
  logic                          ck_save;
  logic [CKPT_BIT-1:0]           ck_id;
  logic                          ck_full;
  logic                          ck_free;
  logic                          ck_rst;
  logic [CKPT_BIT-1:0]           ck_rst_id;
  logic [COMMIT_W-1:0]           rob_wr_ena;
  logic [COMMIT_W*REG_BIT-1:0]   rob_wr_rd;
  logic [COMMIT_W*XLEN-1:0]      rob_wr_val;
  logic [COMMIT_W*ROB_BIT-1:0]   rob_wr_idx;

  modport master (
    output rdy, reg_st, reg_rb, id_rs, id_rn_ena, id_rn_rd, id_rn_idx,
           ck_save, ck_free, ck_rst, ck_rst_id,
           rob_wr_ena, rob_wr_rd, rob_wr_val, rob_wr_idx,
    input  id_src, id_val, ck_id, ck_full
  );

  modport slave (
    input  rdy, reg_st, reg_rb, id_rs, id_rn_ena, id_rn_rd, id_rn_idx,
           ck_save, ck_free, ck_rst, ck_rst_id,
           rob_wr_ena, rob_wr_rd, rob_wr_val, rob_wr_idx,
    output id_src, id_val, ck_id, ck_full
  );
endinterface

// File: rtl/regfile_rat_ckpt_bank.sv
// rtl/regfile_rat_ckpt_bank.sv - circular bank of alias-table snapshots
// Snapshots keep retiring tags so a restored table never points at an already-committed producer.
module regfile_rat_ckpt_bank
  import regfile_rat_ckpt_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        normal,
  input  logic                        save,
  input  logic                        free,
  input  tag_tbl_t                    save_tbl,
  input  logic                        ck_rst,
  input  ckpt_idx_t                   ck_rst_id,
  input  logic [COMMIT_W-1:0]         cm_ena,
  input  logic [COMMIT_W*REG_BIT-1:0] cm_rd,
  input  logic [COMMIT_W*ROB_BIT-1:0] cm_idx,
  output ckpt_idx_t                   ck_id,
  output logic                        ck_full,
  output logic                        restore_ok,
  output tag_tbl_t                    restore_tbl
);
  tag_tbl_t  snap_q [CKPT_N];
  tag_tbl_t  snap_d [CKPT_N];
  ckpt_idx_t head_q, head_d, tail_q, tail_d, rst_age;
  ckpt_cnt_t cnt_q, cnt_d;
  logic      save_ok, free_ok;

  always_comb begin
    rst_age     = ck_rst_id - head_q;
    restore_ok  = ck_rst && ({1'b0, rst_age} < cnt_q);
    restore_tbl = commit_clear(snap_q[ck_rst_id], cm_ena, cm_rd, cm_idx);
    ck_full     = (cnt_q == ckpt_cnt_t'(CKPT_N));
    ck_id       = tail_q;
    free_ok     = free && (cnt_q != '0);
    // Freeing the oldest slot makes room for a save in the same cycle.
    save_ok     = save && (!ck_full || free_ok);
    snap_d      = snap_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (restore_ok) begin
      for (int n = 0; n < CKPT_N; n++) snap_d[n] = commit_clear(snap_q[n], cm_ena, cm_rd, cm_idx);
      tail_d = ck_rst_id;
      cnt_d  = {1'b0, rst_age};
    end else if (normal) begin
      for (int n = 0; n < CKPT_N; n++) snap_d[n] = commit_clear(snap_q[n], cm_ena, cm_rd, cm_idx);
      if (save_ok) begin
        snap_d[tail_q] = save_tbl;
        tail_d         = tail_q + ckpt_idx_t'(1);
      end
      if (free_ok) head_d = head_q + ckpt_idx_t'(1);
      cnt_d = cnt_q + ckpt_cnt_t'(save_ok) - ckpt_cnt_t'(free_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < CKPT_N; n++) snap_q[n] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int n = 0; n < CKPT_N; n++) snap_q[n] <= snap_d[n];
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/regfile_rat_ckpt.sv
// rtl/regfile_rat_ckpt.sv - multi-issue arch regfile with ROB alias table and branch checkpoints
// Reads are combinational with intra-group rename and commit bypass; updates land next edge.
module regfile_rat_ckpt
  import regfile_rat_ckpt_pkg::*;
(
  input logic               clk,
  input logic               rst,
  regfile_rat_ckpt_if.slave bus
);
  tag_tbl_t                   src_q, src_d, ren_tbl, restore_tbl;
  logic [NREG-1:0][XLEN-1:0]  val_q, val_d;
  logic                       normal, restore_ok, commit_en, ck_full;
  ckpt_idx_t                  ck_id;

  assign normal      = bus.rdy && !bus.reg_st;
  assign bus.ck_id   = ck_id;
  assign bus.ck_full = ck_full;

  regfile_rat_ckpt_bank u_bank (
    .clk         (clk),
    .rst         (rst),
    .flush       (bus.reg_rb),
    .normal      (normal),
    .save        (bus.ck_save),
    .free        (bus.ck_free),
    .save_tbl    (ren_tbl),
    .ck_rst      (bus.ck_rst),
    .ck_rst_id   (bus.ck_rst_id),
    .cm_ena      (bus.rob_wr_ena),
    .cm_rd       (bus.rob_wr_rd),
    .cm_idx      (bus.rob_wr_idx),
    .ck_id       (ck_id),
    .ck_full     (ck_full),
    .restore_ok  (restore_ok),
    .restore_tbl (restore_tbl)
  );

  // Later loop iterations override earlier ones, so the youngest matching slot/port wins.
  always_comb begin
    reg_idx_t rs;
    rob_idx_t tag;
    word_t    val;
    bus.id_src = '0;
    bus.id_val = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int s = 0; s < 2; s++) begin
        rs  = bus.id_rs[(2*k+s)*REG_BIT +: REG_BIT];
        tag = src_q[rs];
        val = val_q[rs];
        for (int c = 0; c < COMMIT_W; c++) begin
          if (bus.rob_wr_ena[c] && (bus.rob_wr_rd[c*REG_BIT +: REG_BIT] == rs) &&
              (bus.rob_wr_idx[c*ROB_BIT +: ROB_BIT] == src_q[rs])) begin
            tag = ZERO_ROB_IDX;
            val = bus.rob_wr_val[c*XLEN +: XLEN];
          end
        end
        for (int j = 0; j < k; j++) begin
          if (bus.id_rn_ena[j] && (bus.id_rn_rd[j*REG_BIT +: REG_BIT] == rs)) begin
            tag = bus.id_rn_idx[j*ROB_BIT +: ROB_BIT];
          end
        end
        if (rs == '0) begin
          tag = ZERO_ROB_IDX;
          val = ZERO_WORD;
        end
        bus.id_src[(2*k+s)*ROB_BIT +: ROB_BIT] = tag;
        bus.id_val[(2*k+s)*XLEN +: XLEN]       = val;
      end
    end
  end

  // Renames are applied after the clears so a same-cycle rename of rd keeps its new tag.
  always_comb begin
    ren_tbl = commit_clear(src_q, bus.rob_wr_ena, bus.rob_wr_rd, bus.rob_wr_idx);
    for (int k = 0; k < ISSUE_W; k++) begin
      if (bus.id_rn_ena[k] && (bus.id_rn_rd[k*REG_BIT +: REG_BIT] != '0)) begin
        ren_tbl[bus.id_rn_rd[k*REG_BIT +: REG_BIT]] = bus.id_rn_idx[k*ROB_BIT +: ROB_BIT];
      end
    end
  end

  always_comb begin
    src_d     = src_q;
    val_d     = val_q;
    commit_en = bus.reg_rb || restore_ok || normal;
    if (commit_en) begin
      for (int c = 0; c < COMMIT_W; c++) begin
        if (bus.rob_wr_ena[c] && (bus.rob_wr_rd[c*REG_BIT +: REG_BIT] != '0)) begin
          val_d[bus.rob_wr_rd[c*REG_BIT +: REG_BIT]] = bus.rob_wr_val[c*XLEN +: XLEN];
        end
      end
    end
    if (bus.reg_rb) src_d = '0;
    else if (restore_ok) src_d = restore_tbl;
    else if (normal) src_d = ren_tbl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= '0;
      val_q <= '0;
    end else begin
      src_q <= src_d;
      val_q <= val_d;
    end
  end
endmodule

// File: tb/tb_regfile_rat_ckpt.sv
// tb/tb_regfile_rat_ckpt.sv - directed and randomized bench against a queue-based reference model
module tb_regfile_rat_ckpt;
  import regfile_rat_ckpt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_rat_ckpt_if bus ();
  regfile_rat_ckpt dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [3:0]  src_m  [32];
  logic [31:0] val_m  [32];
  logic [3:0]  snap_m [4][32];
  int          ck_q   [$];
  int          tail_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      src_m[r] = '0;
      val_m[r] = '0;
    end
    ck_q.delete();
    tail_m = 0;
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.reg_st = 1'b0; bus.reg_rb = 1'b0;
    bus.id_rs = '0; bus.id_rn_ena = '0; bus.id_rn_rd = '0; bus.id_rn_idx = '0;
    bus.ck_save = 1'b0; bus.ck_free = 1'b0; bus.ck_rst = 1'b0; bus.ck_rst_id = '0;
    bus.rob_wr_ena = '0; bus.rob_wr_rd = '0; bus.rob_wr_val = '0; bus.rob_wr_idx = '0;
  endtask

  task automatic set_rs(input int p, input int r);
    bus.id_rs[p*5 +: 5] = 5'(r);
  endtask

  task automatic set_ren(input int k, input int r, input int t);
    bus.id_rn_ena[k] = 1'b1;
    bus.id_rn_rd[k*5 +: 5] = 5'(r);
    bus.id_rn_idx[k*4 +: 4] = 4'(t);
  endtask

  task automatic set_cmt(input int c, input int r, input int t, input logic [31:0] v);
    bus.rob_wr_ena[c] = 1'b1;
    bus.rob_wr_rd[c*5 +: 5] = 5'(r);
    bus.rob_wr_idx[c*4 +: 4] = 4'(t);
    bus.rob_wr_val[c*32 +: 32] = v;
  endtask

  function automatic bit cmt_hits(input int r, input logic [3:0] t);
    bit h = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (bus.rob_wr_ena[c] && r != 0 && int'(bus.rob_wr_rd[c*5 +: 5]) == r &&
          bus.rob_wr_idx[c*4 +: 4] == t) h = 1'b1;
    end
    return h;
  endfunction

  // Expected read: check the listed rules in order, youngest candidate first.
  task automatic model_read(input int k, input int s, output logic [3:0] et, output logic [31:0] ev);
    int rs;
    rs = int'(bus.id_rs[(2*k+s)*5 +: 5]);
    et = src_m[rs];
    ev = val_m[rs];
    if (rs == 0) begin
      et = '0; ev = '0; return;
    end
    for (int j = k - 1; j >= 0; j--) begin
      if (bus.id_rn_ena[j] && int'(bus.id_rn_rd[j*5 +: 5]) == rs) begin
        et = bus.id_rn_idx[j*4 +: 4]; return;
      end
    end
    for (int c = 1; c >= 0; c--) begin
      if (bus.rob_wr_ena[c] && int'(bus.rob_wr_rd[c*5 +: 5]) == rs && bus.rob_wr_idx[c*4 +: 4] == src_m[rs]) begin
        et = '0; ev = bus.rob_wr_val[c*32 +: 32]; return;
      end
    end
  endtask

  task automatic apply_vals();
    for (int c = 0; c < 2; c++) begin
      if (bus.rob_wr_ena[c] && bus.rob_wr_rd[c*5 +: 5] != 0) val_m[int'(bus.rob_wr_rd[c*5 +: 5])] = bus.rob_wr_val[c*32 +: 32];
    end
  endtask

  task automatic clear_snaps();
    foreach (ck_q[i]) begin
      for (int r = 0; r < 32; r++) if (cmt_hits(r, snap_m[ck_q[i]][r])) snap_m[ck_q[i]][r] = '0;
    end
  endtask

  task automatic model_clock();
    int pos, id;
    bit free_ok, save_ok;
    logic [3:0] nt [32];
    pos = -1;
    id  = int'(bus.ck_rst_id);
    if (bus.ck_rst) foreach (ck_q[i]) if (ck_q[i] == id) pos = i;
    if (bus.reg_rb) begin
      apply_vals();
      for (int r = 0; r < 32; r++) src_m[r] = '0;
      ck_q.delete();
      tail_m = 0;
    end else if (pos >= 0) begin
      apply_vals();
      for (int r = 0; r < 32; r++) src_m[r] = cmt_hits(r, snap_m[id][r]) ? 4'd0 : snap_m[id][r];
      clear_snaps();
      while (ck_q.size() > pos) void'(ck_q.pop_back());
      tail_m = id;
    end else if (bus.rdy && !bus.reg_st) begin
      for (int r = 0; r < 32; r++) nt[r] = cmt_hits(r, src_m[r]) ? 4'd0 : src_m[r];
      for (int k = 0; k < 2; k++) begin
        if (bus.id_rn_ena[k] && bus.id_rn_rd[k*5 +: 5] != 0) nt[int'(bus.id_rn_rd[k*5 +: 5])] = bus.id_rn_idx[k*4 +: 4];
      end
      clear_snaps();
      free_ok = bus.ck_free && ck_q.size() > 0;
      save_ok = bus.ck_save && (ck_q.size() < 4 || free_ok);
      if (free_ok) void'(ck_q.pop_front());
      if (save_ok) begin
        for (int r = 0; r < 32; r++) snap_m[tail_m][r] = nt[r];
        ck_q.push_back(tail_m);
        tail_m = (tail_m + 1) % 4;
      end
      apply_vals();
      for (int r = 0; r < 32; r++) src_m[r] = nt[r];
    end
  endtask

  task automatic step();
    logic [3:0]  et;
    logic [31:0] ev;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        model_read(k, s, et, ev);
        chk($sformatf("src_p%0d", 2*k+s), 32'(bus.id_src[(2*k+s)*4 +: 4]), 32'(et));
        if (et == 0) chk($sformatf("val_p%0d", 2*k+s), bus.id_val[(2*k+s)*32 +: 32], ev);
      end
    end
    chk("ck_id", 32'(bus.ck_id), 32'(tail_m));
    chk("ck_full", 32'(bus.ck_full), 32'(ck_q.size() == 4));
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ck_full", 32'(bus.ck_full), 32'd0);
    chk("rst_ck_id", 32'(bus.ck_id), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    idle(); set_cmt(0, 6, 1, 32'h1234_0066); step();
    idle(); set_ren(0, 5, 3); set_rs(2, 5); set_rs(3, 6); #1;
    chk("intra_dep_tag", 32'(bus.id_src[8 +: 4]), 32'd3);
    chk("intra_ready_tag", 32'(bus.id_src[12 +: 4]), 32'd0);
    chk("intra_ready_val", bus.id_val[96 +: 32], 32'h1234_0066);
    step();

    idle(); set_ren(0, 9, 4); step();
    idle(); set_cmt(0, 9, 4, 32'hDEAD); set_rs(0, 9); #1;
    chk("bypass_tag", 32'(bus.id_src[0 +: 4]), 32'd0);
    chk("bypass_val", bus.id_val[0 +: 32], 32'hDEAD);
    step();
    idle(); set_rs(0, 9); #1;
    chk("cleared_tag", 32'(bus.id_src[0 +: 4]), 32'd0);
    step();

    idle(); set_ren(0, 7, 2); step();
    idle(); set_cmt(1, 7, 2, 32'h77); set_ren(1, 7, 6); step();
    idle(); set_rs(0, 7); #1;
    chk("ren_beats_clr", 32'(bus.id_src[0 +: 4]), 32'd6);
    step();
    idle(); bus.reg_rb = 1'b1; step();
    idle(); set_rs(0, 7); #1;
    chk("commit_val_kept", bus.id_val[0 +: 32], 32'h77);
    step();

    idle(); set_ren(0, 3, 5); bus.ck_save = 1'b1; #1;
    chk("save_ck_id", 32'(bus.ck_id), 32'd0);
    step();
    idle(); set_ren(0, 3, 7); bus.ck_save = 1'b1; step();
    idle(); bus.ck_rst = 1'b1; bus.ck_rst_id = 2'd0; step();
    idle(); set_rs(0, 3); #1;
    chk("restore_tag", 32'(bus.id_src[0 +: 4]), 32'd5);
    chk("restore_ck_id", 32'(bus.ck_id), 32'd0);
    chk("restore_full", 32'(bus.ck_full), 32'd0);
    step();

    repeat (4) begin idle(); bus.ck_save = 1'b1; step(); end
    idle(); #1;
    chk("full_after4", 32'(bus.ck_full), 32'd1);
    bus.ck_save = 1'b1; step();
    idle(); #1;
    chk("fifth_ignored_id", 32'(bus.ck_id), 32'd0);
    bus.ck_free = 1'b1; bus.ck_save = 1'b1; step();
    idle(); #1;
    chk("free_save_full", 32'(bus.ck_full), 32'd1);
    chk("free_save_id", 32'(bus.ck_id), 32'd1);
    bus.ck_free = 1'b1; step();

    idle(); set_rs(0, 9); set_rs(1, 6); set_rs(2, 7); set_rs(3, 3); #1;
    rst = 1'b0; #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("midrst_src_p%0d", p), 32'(bus.id_src[p*4 +: 4]), 32'd0);
      chk($sformatf("midrst_val_p%0d", p), bus.id_val[p*32 +: 32], 32'd0);
    end
    chk("midrst_ck_id", 32'(bus.ck_id), 32'd0);
    chk("midrst_ck_full", 32'(bus.ck_full), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int it = 0; it < 600; it++) begin
      int r;
      idle();
      bus.rdy    = ($urandom % 8) != 0;
      bus.reg_st = ($urandom % 10) == 0;
      bus.reg_rb = ($urandom % 40) == 0;
      if (ck_q.size() > 0 && ($urandom % 12) == 0) begin
        bus.ck_rst = 1'b1;
        bus.ck_rst_id = 2'(ck_q[$urandom % ck_q.size()]);
      end
      bus.ck_save = ($urandom % 3) == 0;
      bus.ck_free = ($urandom % 4) == 0;
      for (int p = 0; p < 4; p++) set_rs(p, int'($urandom % 8));
      for (int k = 0; k < 2; k++) if ($urandom % 2) set_ren(k, int'($urandom % 8), int'(1 + $urandom % 15));
      for (int c = 0; c < 2; c++) begin
        if ($urandom % 2) begin
          r = int'($urandom % 8);
          set_cmt(c, r, (src_m[r] != 0 && ($urandom % 4) != 0) ? int'(src_m[r]) : int'(1 + $urandom % 15), $urandom);
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
